mantissa_addsub_pipe: RTL

Parametrised, pipelined successor to the floating-point datapath's combinational mantissa adder. Adds or subtracts two unsigned MW-bit mantissas and produces a raw (MW+1)-bit result. It also produces the sign of a subtraction, a normalized MW-bit mantissa and a signed exponent adjustment. The block sits between the exponent-align stage and the rounding/exponent-update stage of the FP add/sub unit, with valid/ready flow control on both sides.

---
 rtl/fp_pkg.sv | 23 ++
 rtl/mant_lzc.sv | 31 +++
 rtl/mantissa_addsub_pipe.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// ============================================================================
// Module : fp_pkg
// Brief  : Shared definitions for the FP add/sub datapath: mantissa
//          operation encodings and the exponent-adjust width function.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fp_pkg;

  // Mantissa operation select encodings
  localparam logic MAS_ADD = 1'b0;
  localparam logic MAS_SUB = 1'b1;

  // Width of the signed exponent adjustment for a given mantissa width:
  // enough magnitude bits for a shift of 0..MW plus a sign bit.
  function automatic int eaw_width(input int mw);
    return $clog2(mw + 1) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mant_lzc.sv
// ============================================================================
// Module : mant_lzc
// Brief  : Combinational leading-zero counter over a W-bit vector. Returns
//          W with allzero=1 when the vector is zero.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mant_lzc #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  din,
  output logic [CW-1:0] cnt,
  output logic          allzero
);

  // Scan upward so the highest set bit is the last one to set the count
  always_comb begin
    cnt     = CW'(W);
    allzero = (din == '0);
    for (int i = 0; i < W; i++) begin
      if (din[i]) begin
        cnt = CW'(W - 1 - i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mantissa_addsub_pipe.sv
// ============================================================================
// Module : mantissa_addsub_pipe
// Brief  : Two-stage pipelined mantissa add/subtract with normalization.
//          Stage 1 forms the raw sum or magnitude difference; stage 2
//          normalizes it and produces the exponent adjustment and sticky.
//          Valid/ready handshake on both sides, two results in flight.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mantissa_addsub_pipe
  import fp_pkg::*;
#(
  parameter int MW  = 8,
  parameter int EAW = eaw_width(MW)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [MW-1:0]  pm,
  input  logic [MW-1:0]  qm,
  input  logic           mas,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [MW:0]    sm,
  output logic           neg,
  output logic [MW-1:0]  nm,
  output logic [EAW-1:0] exp_adj,
  output logic           sticky,
  output logic           zero
);

  localparam int c_lzw = $clog2(MW + 1);

  // ---------------------------------------------------------------- control
  logic r_s1_valid;
  logic r_out_valid;
  logic w_out_adv;
  logic w_s1_adv;
  logic w_accept;

  assign w_out_adv = !r_out_valid || out_ready;
  assign w_s1_adv  = r_s1_valid && w_out_adv;
  assign in_ready  = !r_s1_valid || w_s1_adv;
  assign w_accept  = in_valid && in_ready;

  // ---------------------------------------------------------------- stage 1
  logic [MW:0]   w_sum;
  logic          w_q_gt_p;
  logic [MW-1:0] w_diff;
  logic [MW:0]   w_raw;
  logic          w_neg;

  // Subtraction swaps operands on borrow so the result is always a magnitude
  always_comb begin
    w_sum    = {1'b0, pm} + {1'b0, qm};
    w_q_gt_p = (qm > pm);
    w_diff   = w_q_gt_p ? (qm - pm) : (pm - qm);
    if (mas == MAS_SUB) begin
      w_raw = {1'b0, w_diff};
      w_neg = w_q_gt_p;
    end else begin
      w_raw = w_sum;
      w_neg = 1'b0;
    end
  end

  logic [MW:0] r_s1_raw;
  logic        r_s1_neg;

  // Stage-1 register: refills whenever it is empty or draining forward
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_raw   <= '0;
      r_s1_neg   <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_raw <= w_raw;
        r_s1_neg <= w_neg;
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [c_lzw-1:0] w_lz;
  logic             w_allzero;

  mant_lzc #(
    .W  (MW),
    .CW (c_lzw)
  ) u_lzc (
    .din     (r_s1_raw[MW-1:0]),
    .cnt     (w_lz),
    .allzero (w_allzero)
  );

  logic [MW-1:0]  w_nm;
  logic [EAW-1:0] w_exp_adj;
  logic           w_sticky;
  logic           w_zero;

  // Normalize: carry-out shifts right by one, otherwise shift left by lz
  always_comb begin
    w_nm      = '0;
    w_exp_adj = '0;
    w_sticky  = 1'b0;
    w_zero    = 1'b0;
    if (r_s1_raw[MW]) begin
      w_nm      = r_s1_raw[MW:1];
      w_exp_adj = EAW'(1);
      w_sticky  = r_s1_raw[0];
    end else if (w_allzero) begin
      w_zero    = 1'b1;
    end else begin
      w_nm      = r_s1_raw[MW-1:0] << w_lz;
      w_exp_adj = EAW'(0) - EAW'(w_lz);
    end
  end

  logic [MW:0]    r_sm;
  logic           r_neg;
  logic [MW-1:0]  r_nm;
  logic [EAW-1:0] r_exp_adj;
  logic           r_sticky;
  logic           r_zero;

  // Output register: holds its contents while downstream stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sm        <= '0;
      r_neg       <= 1'b0;
      r_nm        <= '0;
      r_exp_adj   <= '0;
      r_sticky    <= 1'b0;
      r_zero      <= 1'b0;
    end else if (w_out_adv) begin
      r_out_valid <= r_s1_valid;
      if (w_s1_adv) begin
        r_sm      <= r_s1_raw;
        r_neg     <= r_s1_neg;
        r_nm      <= w_nm;
        r_exp_adj <= w_exp_adj;
        r_sticky  <= w_sticky;
        r_zero    <= w_zero;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign sm        = r_sm;
  assign neg       = r_neg;
  assign nm        = r_nm;
  assign exp_adj   = r_exp_adj;
  assign sticky    = r_sticky;
  assign zero      = r_zero;

endmodule

`default_nettype wire
